// File: rtl/byte_unpack_seq.sv
// byte_unpack_seq: accepts a packed {A,B} operand pair and streams its four
// signed bytes out one per beat, sign-extended to OUT_W, in RED pairing order
// (a, c, b, d). Optional feature macro: UNPACK_SUM_EN adds a running sum of
// the beats (sum_out/sum_valid) that reproduces the RED result.
module byte_unpack_seq #(
   parameter int unsigned LANE_W = 8,
   parameter int unsigned NLANES = 4,
   parameter int unsigned OUT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*LANE_W-1:0] A,
   input  logic [2*LANE_W-1:0] B,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_W-1:0]    out_data,
   output logic [1:0]          out_idx,
   output logic                out_last,
`ifdef UNPACK_SUM_EN
   output logic [OUT_W-1:0]    sum_out,
   output logic                sum_valid,
`endif
   output logic                busy
);

   typedef enum logic [0:0] {StIdle, StEmit} state_e;

   state_e                  state_q, state_d;
   logic [4*LANE_W-1:0]     hold_q, hold_d;
   logic [1:0]              idx_q, idx_d;
   logic [LANE_W-1:0]       lane;
   logic [OUT_W-1:0]        lane_ext;
   logic                    accept;
   logic                    beat_hs;
   logic                    last_beat;

   assign last_beat = (state_q == StEmit) && (idx_q == 2'(NLANES - 1));
   assign beat_hs   = (state_q == StEmit) && out_ready;
   // A new word may enter while idle or on the cycle the last beat leaves.
   assign in_ready  = (state_q == StIdle) || (last_beat && out_ready);
   assign accept    = in_valid && in_ready;

   // Lane select: hold = {A, B}; order a, c, b, d matches the RED pairing.
   always_comb begin
      lane = '0;
      unique case (idx_q)
         2'd0: lane = hold_q[4*LANE_W-1:3*LANE_W];
         2'd1: lane = hold_q[2*LANE_W-1:LANE_W];
         2'd2: lane = hold_q[3*LANE_W-1:2*LANE_W];
         2'd3: lane = hold_q[LANE_W-1:0];
         default: lane = '0;
      endcase
   end

   assign lane_ext  = {{(OUT_W - LANE_W){lane[LANE_W-1]}}, lane};
   assign out_valid = (state_q == StEmit);
   assign busy      = (state_q == StEmit);
   assign out_data  = (state_q == StEmit) ? lane_ext : '0;
   assign out_idx   = idx_q;
   assign out_last  = last_beat;

   // Next-state: capture on acceptance, step idx on each beat handshake.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               hold_d  = {A, B};
               idx_d   = '0;
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (out_ready) begin
               idx_d = idx_q + 2'd1;
               if (last_beat) begin
                  if (accept) begin
                     hold_d = {A, B};
                     idx_d  = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register; reset discards any partly drained word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         hold_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
      end
   end

`ifdef UNPACK_SUM_EN
   logic [OUT_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] sum_q, sum_d;
   logic             sum_valid_q, sum_valid_d;

   // Accumulate beats; the result is latched separately so a word accepted
   // on the last-beat cycle cannot clobber the finished sum.
   always_comb begin
      acc_d       = acc_q;
      sum_d       = sum_q;
      sum_valid_d = 1'b0;
      if (beat_hs) begin
         acc_d = acc_q + lane_ext;
         if (last_beat) begin
            sum_d       = acc_q + lane_ext;
            sum_valid_d = 1'b1;
         end
      end
      if (accept) begin
         acc_d = '0;
      end
   end

   // Sum registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         sum_valid_q <= sum_valid_d;
      end
   end

   assign sum_out   = sum_q;
   assign sum_valid = sum_valid_q;
`else
   logic unused_beat_hs;
   assign unused_beat_hs = beat_hs;
`endif

endmodule

// File: tb/tb_byte_unpack_seq.sv
// Directed testbench for byte_unpack_seq. Sum checks are compiled in only
// when UNPACK_SUM_EN is defined.
module tb_byte_unpack_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [1:0]  out_idx;
   logic        out_last;
   logic        busy;
`ifdef UNPACK_SUM_EN
   logic [15:0] sum_out;
   logic        sum_valid;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] exp_beat [8];

   byte_unpack_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
`ifdef UNPACK_SUM_EN
      .sum_out   (sum_out),
      .sum_valid (sum_valid),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
      #12;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0 || out_idx !== 2'd0 ||
          out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset: valid=%b data=%h idx=%0d last=%b busy=%b rdy=%b, want 0 0000 0 0 0 1",
                  out_valid, out_data, out_idx, out_last, busy, in_ready);
      end
`ifdef UNPACK_SUM_EN
      n_checks++;
      if (sum_out !== 16'h0 || sum_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sum: sum=%h sv=%b, want 0000 0", sum_out, sum_valid);
      end
`endif
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic();
      exp_beat[0] = 16'h007F; exp_beat[1] = 16'h0001;
      exp_beat[2] = 16'hFF80; exp_beat[3] = 16'h0002;
      @(negedge clk); in_valid = 1'b1; A = 16'h7F80; B = 16'h0102; out_ready = 1'b1; #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_idle: rdy=%b valid=%b, want 1 0", in_ready, out_valid);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); in_valid = 1'b0; #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_beat[k] || out_idx !== 2'(k) ||
             out_last !== (k == 3) || busy !== 1'b1 || in_ready !== (k == 3)) begin
            n_fail++;
            $display("FAIL basic_beat%0d: v=%b data=%h idx=%0d last=%b rdy=%b, want 1 %h %0d %b %b",
                     k, out_valid, out_data, out_idx, out_last, in_ready, exp_beat[k], k,
                     k == 3, k == 3);
         end
      end
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done: valid=%b busy=%b, want 0 0", out_valid, busy);
      end
`ifdef UNPACK_SUM_EN
      n_checks++;
      if (sum_valid !== 1'b1 || sum_out !== 16'h0002) begin
         n_fail++;
         $display("FAIL basic_sum: sv=%b sum=%h, want 1 0002", sum_valid, sum_out);
      end
      @(negedge clk); #1;
      n_checks++;
      if (sum_valid !== 1'b0 || sum_out !== 16'h0002) begin
         n_fail++;
         $display("FAIL basic_sum_hold: sv=%b sum=%h, want 0 0002", sum_valid, sum_out);
      end
`endif
   endtask

   task automatic test_backpressure();
      int beats = 0;
      exp_beat[0] = 16'h007F; exp_beat[1] = 16'h0001;
      exp_beat[2] = 16'hFF80; exp_beat[3] = 16'h0002;
      @(negedge clk); in_valid = 1'b1; A = 16'h7F80; B = 16'h0102; out_ready = 1'b1;
      @(negedge clk); in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF; #1;
      // beat 0 handshakes at the next edge
      beats++;
      @(negedge clk); out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 16'h0001 || out_idx !== 2'd1 ||
             in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall%0d: v=%b data=%h idx=%0d rdy=%b, want 1 0001 1 0",
                     k, out_valid, out_data, out_idx, in_ready);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_beat[k] || out_idx !== 2'(k)) begin
            n_fail++;
            $display("FAIL bp_beat%0d: v=%b data=%h idx=%0d, want 1 %h %0d",
                     k, out_valid, out_data, out_idx, exp_beat[k], k);
         end
         beats++;
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || beats != 4) begin
         n_fail++;
         $display("FAIL bp_done: valid=%b beats=%0d, want 0 4", out_valid, beats);
      end
   endtask

   task automatic test_back_to_back();
      exp_beat[0] = 16'h007F; exp_beat[1] = 16'h0001;
      exp_beat[2] = 16'hFF80; exp_beat[3] = 16'h0002;
      exp_beat[4] = 16'h0005; exp_beat[5] = 16'h007E;
      exp_beat[6] = 16'hFFFB; exp_beat[7] = 16'hFF81;
      @(negedge clk); in_valid = 1'b1; A = 16'h7F80; B = 16'h0102; out_ready = 1'b1; #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_idle_rdy: rdy=%b, want 1", in_ready);
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) begin A = 16'h05FB; B = 16'h7E81; end
         if (k == 7) in_valid = 1'b0;
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_beat[k] || out_idx !== 2'(k % 4) ||
             in_ready !== (k % 4 == 3)) begin
            n_fail++;
            $display("FAIL b2b_beat%0d: v=%b data=%h idx=%0d rdy=%b, want 1 %h %0d %b",
                     k, out_valid, out_data, out_idx, in_ready, exp_beat[k], k % 4,
                     k % 4 == 3);
         end
`ifdef UNPACK_SUM_EN
         if (k == 4) begin
            n_checks++;
            if (sum_valid !== 1'b1 || sum_out !== 16'h0002) begin
               n_fail++;
               $display("FAIL b2b_sum1: sv=%b sum=%h, want 1 0002", sum_valid, sum_out);
            end
         end
`endif
      end
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
      end
`ifdef UNPACK_SUM_EN
      n_checks++;
      if (sum_valid !== 1'b1 || sum_out !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL b2b_sum2: sv=%b sum=%h, want 1 ffff", sum_valid, sum_out);
      end
`endif
   endtask

   task automatic test_reset_mid_word();
      @(negedge clk); in_valid = 1'b1; A = 16'h7F80; B = 16'h0102; out_ready = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      n_checks++;
      if (out_idx !== 2'd2 || out_data !== 16'hFF80) begin
         n_fail++;
         $display("FAIL rst_pre: idx=%0d data=%h, want 2 ff80", out_idx, out_data);
      end
      rst_n = 1'b0; #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== 2'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid: valid=%b busy=%b idx=%0d rdy=%b, want 0 0 0 1",
                  out_valid, busy, out_idx, in_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      exp_beat[0] = 16'h0003; exp_beat[1] = 16'h0005;
      exp_beat[2] = 16'h0004; exp_beat[3] = 16'h0006;
      @(negedge clk); in_valid = 1'b1; A = 16'h0304; B = 16'h0506;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); in_valid = 1'b0; #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_beat[k] || out_idx !== 2'(k)) begin
            n_fail++;
            $display("FAIL rst_new_beat%0d: v=%b data=%h idx=%0d, want 1 %h %0d",
                     k, out_valid, out_data, out_idx, exp_beat[k], k);
         end
      end
      @(negedge clk); #1;
`ifdef UNPACK_SUM_EN
      n_checks++;
      if (sum_valid !== 1'b1 || sum_out !== 16'h0012) begin
         n_fail++;
         $display("FAIL rst_new_sum: sv=%b sum=%h, want 1 0012", sum_valid, sum_out);
      end
`endif
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_new_done: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_negative();
      @(negedge clk); in_valid = 1'b1; A = 16'h8080; B = 16'h8080; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); in_valid = 1'b0; #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 16'hFF80 || out_idx !== 2'(k)) begin
            n_fail++;
            $display("FAIL neg_beat%0d: v=%b data=%h idx=%0d, want 1 ff80 %0d",
                     k, out_valid, out_data, out_idx, k);
         end
      end
      @(negedge clk); #1;
`ifdef UNPACK_SUM_EN
      n_checks++;
      if (sum_valid !== 1'b1 || sum_out !== 16'hFE00) begin
         n_fail++;
         $display("FAIL neg_sum: sv=%b sum=%h, want 1 fe00", sum_valid, sum_out);
      end
`endif
   endtask

   task automatic test_late_offer();
      @(negedge clk); in_valid = 1'b1; A = 16'h7F80; B = 16'h0102; out_ready = 1'b1;
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++;
      if (out_data !== 16'h007F || out_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL late_beat0: data=%h idx=%0d, want 007f 0", out_data, out_idx);
      end
      @(negedge clk); in_valid = 1'b1; A = 16'h1234; B = 16'h5678; #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_idx !== 2'd1) begin
         n_fail++;
         $display("FAIL late_idx1: rdy=%b idx=%0d, want 0 1", in_ready, out_idx);
      end
      @(negedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL late_idx2: rdy=%b idx=%0d, want 0 2", in_ready, out_idx);
      end
      @(negedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_idx !== 2'd3 || out_data !== 16'h0002) begin
         n_fail++;
         $display("FAIL late_idx3: rdy=%b idx=%0d data=%h, want 1 3 0002",
                  in_ready, out_idx, out_data);
      end
      exp_beat[0] = 16'h0012; exp_beat[1] = 16'h0056;
      exp_beat[2] = 16'h0034; exp_beat[3] = 16'h0078;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) begin in_valid = 1'b0; A = 16'hFFFF; B = 16'hFFFF; end
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_beat[k] || out_idx !== 2'(k)) begin
            n_fail++;
            $display("FAIL late_new_beat%0d: v=%b data=%h idx=%0d, want 1 %h %0d",
                     k, out_valid, out_data, out_idx, exp_beat[k], k);
         end
      end
      @(negedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL late_done: valid=%b, want 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_word();
      test_negative();
      test_late_offer();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
